// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter, LSB first, CLK_PER_BIT clocks per bit, idle-high line.
// Define UART_TX_BLOCK_EN to add the `block` flow-control hold input.
module uart_tx_serializer #(
  parameter int CLK_PER_BIT = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       new_data,
`ifdef UART_TX_BLOCK_EN
  input  logic       block,
`endif
  output logic       busy,
  output logic       tx
);

  localparam int CTR_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA,
    STOP_BIT
  } state_t;

  state_t           r_state;
  logic [CTR_W-1:0] r_clk_ctr;
  logic [2:0]       r_bit_ctr;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             r_busy;
  logic             w_block;
  logic             w_bit_end;
  logic             w_accept;
  logic [2:0]       w_next_bit;

`ifdef UART_TX_BLOCK_EN
  logic r_block;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_block <= 1'b0;
    end else begin
      r_block <= block;
    end
  end

  assign w_block = r_block;
`else
  assign w_block = 1'b0;
`endif

  assign w_bit_end  = (r_clk_ctr == CTR_LAST);
  assign w_accept   = (r_state == IDLE) && new_data && !w_block;
  assign w_next_bit = r_bit_ctr + 3'd1;

  // Both terms are flops, so busy has no combinational path from any input.
  assign busy = r_busy | w_block;
  assign tx   = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_bit_ctr <= 3'd0;
      r_clk_ctr <= '0;
      r_shift   <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (w_accept) begin
            r_shift   <= data;
            r_clk_ctr <= '0;
            r_bit_ctr <= 3'd0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= START_BIT;
          end
        end
        START_BIT: begin
          if (w_bit_end) begin
            r_clk_ctr <= '0;
            r_tx      <= r_shift[0];
            r_state   <= DATA;
          end else begin
            r_clk_ctr <= r_clk_ctr + CTR_W'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_clk_ctr <= '0;
            if (r_bit_ctr == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP_BIT;
            end else begin
              r_bit_ctr <= w_next_bit;
              r_tx      <= r_shift[w_next_bit];
            end
          end else begin
            r_clk_ctr <= r_clk_ctr + CTR_W'(1);
          end
        end
        STOP_BIT: begin
          if (w_bit_end) begin
            r_clk_ctr <= '0;
            r_busy    <= 1'b0;
            r_tx      <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_clk_ctr <= r_clk_ctr + CTR_W'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Byte-to-serial UART transmitter. Consumes the parallel byte stream from the message printer (`tx_data`/`new_tx_data`/`tx_busy` handshake) and drives the FPGA serial TX pin: 8N1 framing, LSB first, fixed baud set by clock division. Sits directly downstream of the message printer; its `busy` output is that block's `tx_busy` input.

## Interface
- `CLK_PER_BIT`, default 50: clock cycles per serial bit (50 MHz / 1 Mbaud). Legal range 2..65535.
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high; clock `clk`
- `data`  in  8  byte to send; sampled only on acceptance
- `new_data`  in  1  single-cycle request to send `data`
- `busy`  out  1  registered; high = request will be ignored
- `tx`  out  1  registered serial line, idle high
- `block`  in  1  flow-control hold; present only with `UART_TX_BLOCK_EN`

## Operation
- States: IDLE, START_BIT, DATA, STOP_BIT.
- Reset values: state IDLE, `tx`=1, `busy`=0, bit counter 0, clock counter 0, shift register 0.
- IDLE: `tx`=1, `busy`=0. If `new_data`=1, latch `data` into the shift register, clear counters, go to START_BIT.
- START_BIT: `tx`=0 for `CLK_PER_BIT` cycles, then DATA.
- DATA: `tx`=shift register bit `bit_ctr` (bit 0 first), each held `CLK_PER_BIT` cycles; after bit 7, go to STOP_BIT.
- STOP_BIT: `tx`=1 for `CLK_PER_BIT` cycles, then IDLE.
- `busy`=1 in every state except IDLE.
- Clock counter width `$clog2(CLK_PER_BIT)`; it counts 0..`CLK_PER_BIT`-1 and wraps to 0 at each bit boundary. Bit counter is 3 bits and advances at each DATA bit boundary.
- `new_data` while `busy`=1 is dropped: no queuing, no corruption of the frame in flight.
- `data` changing after acceptance has no effect on the frame in flight.
- `rst` mid-frame: the next cycle is IDLE with `tx`=1 and `busy`=0. The partial frame is abandoned.
- Simultaneous `rst` and `new_data`: reset wins; the byte is not accepted.

## Timing
- Acceptance in cycle T (IDLE, `new_data`=1). With `C`=`CLK_PER_BIT`:
  - `busy`=1 and `tx`=0 from T+1.
  - Start bit: cycles T+1..T+C.
  - Data bit i: cycles T+1+C(i+1)..T+C(i+2).
  - Stop bit: cycles T+1+9C..T+10C.
  - IDLE with `busy`=0 at T+10C+1.
- The next acceptance is possible at T+10C+1. Back-to-back frames have a minimum line period of 10C+1 cycles, including one idle-high cycle between frames.
- `busy` is registered, so upstream may assert `new_data` combinationally from `!busy` in the same cycle.

## Configuration
- `UART_TX_BLOCK_EN` defined:
  - `block` port exists and is registered once internally.
  - While the registered `block` is 1 in IDLE, `busy`=1 and `new_data` is ignored.
  - A frame already started always completes.
  - `busy` reflects `block` changes 1 cycle after the input changes.
- `UART_TX_BLOCK_EN` undefined: no `block` port; behaviour is exactly as above with block permanently 0.

## Test plan
All scenarios use `CLK_PER_BIT`=4.
- Reset: hold `rst` 3 cycles -> `tx`=1, `busy`=0; no `tx` activity for 50 cycles.
- Single byte: `new_data` pulse with `data`=8'hA5 at T -> `tx` sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles from T+1; `busy` high over T+1..T+40; low at T+41.
- Back-to-back:
  - "0" (8'h30) accepted at T.
  - "1" (8'h31) requested at T+41, when `busy` is first low.
  - Required: second start bit at T+42; both bytes decode correctly on a bench UART monitor.
- Request while busy: `new_data` with 8'hFF at T+10, during a frame of 8'h00 -> frame stays 8'h00; 8'hFF is never transmitted.
- Reset mid-frame: `rst` at T+15 -> `tx`=1, `busy`=0 at T+16; a new 8'h55 accepted at T+17 transmits correctly.
- Block (with `UART_TX_BLOCK_EN`):
  - `block`=1 at T+5, mid-frame -> frame completes; `busy` stays 1 after the stop bit; `new_data` with 8'h12 is ignored.
  - `block`=0 -> `busy`=0 one cycle later, then 8'h12 is accepted and sent.
